// File: rtl/sigmoid_backprop.sv
// ---------------------------------------------------------------------------
// sigmoid_backprop
//
// Backward pass of the piecewise-linear sigmoid. For each accepted pair
// (y, e) in signed Q8.24 it produces
//     d     = yc * (1 - yc)          (yc = y clamped to [0, 1])
//     delta = e * d
// One signed WIDTH x WIDTH multiplier is shared between the two products. A
// four-state FSM (IDLE -> MUL1 -> MUL2 -> HOLD) sequences it.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   y_in / err_in valid
//   in_ready   high only in IDLE; the block can accept a pair
//   y_in       forward activation, Q8.24
//   err_in     upstream error, Q8.24
//   out_valid  high in HOLD; delta_out / d_out valid
//   out_ready  consumer accepts the result
//   delta_out  e*y*(1-y), Q8.24
//   d_out      y*(1-y), Q8.24
// ---------------------------------------------------------------------------
module sigmoid_backprop #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] err_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] delta_out,
    output logic [WIDTH-1:0] d_out
);

    localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL1 = 2'd1,
        MUL2 = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] y_q, y_d;
    logic signed [WIDTH-1:0] e_q, e_d;
    logic signed [WIDTH-1:0] d_q, d_d;
    logic signed [WIDTH-1:0] delta_q, delta_d;

    logic signed [WIDTH-1:0]   y_clamped;
    logic signed [WIDTH-1:0]   mul_a, mul_b;
    logic signed [2*WIDTH-1:0] mul_prod;
    logic signed [WIDTH-1:0]   mul_res;

    // Clamp the activation to [0, ONE], so that d is confined to [0, 0.25].
    always_comb begin
        if ($signed(y_in) < 0) begin
            y_clamped = '0;
        end else if ($signed(y_in) > ONE) begin
            y_clamped = ONE;
        end else begin
            y_clamped = $signed(y_in);
        end
    end

    // The shared multiplier. Its operands are selected from the current state
    // only, so the product never depends on the next-state logic.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            MUL1: begin
                mul_a = y_q;
                mul_b = ONE - y_q;
            end
            MUL2: begin
                mul_a = e_q;
                mul_b = d_q;
            end
            default: ;
        endcase
    end

    assign mul_prod = mul_a * mul_b;
    // The arithmetic shift floors toward -inf. No rounding and no saturation
    // are applied: |d| <= 0.25 keeps |delta| well inside the Q8.24 range.
    assign mul_res  = WIDTH'(mul_prod >>> FRAC);

    // NOTE: every output of this block gets a default first. Without one, some
    // path through the case statement would leave a signal unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        e_d       = e_q;
        d_d       = d_q;
        delta_d   = delta_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    y_d     = y_clamped;
                    e_d     = $signed(err_in);
                    state_d = MUL1;
                end
            end
            MUL1: begin
                d_d     = mul_res;
                state_d = MUL2;
            end
            MUL2: begin
                delta_d = mul_res;
                state_d = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments, so every
    // register samples the values that were present before the clock edge.
    // NOTE: the datapath registers are reset along with the FSM. This keeps a
    // result that was aborted by reset from ever reaching delta_out / d_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            y_q     <= '0;
            e_q     <= '0;
            d_q     <= '0;
            delta_q <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            e_q     <= e_d;
            d_q     <= d_d;
            delta_q <= delta_d;
        end
    end

    assign delta_out = delta_q;
    assign d_out     = d_q;

endmodule

// File: tb/tb_sigmoid_backprop.sv
module tb_sigmoid_backprop;

    localparam logic [31:0] ONE = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] y_in;
    logic [31:0] err_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] delta_out;
    logic [31:0] d_out;

    int checks = 0;
    int errors = 0;

    sigmoid_backprop #(.WIDTH(32), .FRAC(24)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_in      (y_in),
        .err_in    (err_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .delta_out (delta_out),
        .d_out     (d_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] y;
        logic [31:0] e;
        logic [31:0] exp_d;
        logic [31:0] exp_delta;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Single-cycle step: the inputs change and the outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one full transaction with out_ready held high. The task also checks the
    // handshake timing: out_valid is seen in the third cycle after the accepting
    // cycle, and the block is back in IDLE the cycle after the result is taken.
    task automatic run_txn(input string tag, input logic [31:0] y, input logic [31:0] e,
                           output logic [31:0] d, output logic [31:0] delta);
        int guard;
        int lat;
        y_in      = y;
        err_in    = e;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        check({tag, "_accept_ready"}, {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        // Garbage applied after acceptance must not affect the result.
        y_in     = 32'hDEAD_BEEF;
        err_in   = 32'h1234_5678;
        check({tag, "_busy_in_ready"}, {31'b0, in_ready}, 32'd0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, 32'd3);
        check({tag, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
        d     = d_out;
        delta = delta_out;
        step();
        check({tag, "_idle_in_ready"}, {31'b0, in_ready}, 32'd1);
        check({tag, "_idle_out_valid"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] d_got, delta_got, d_hold, delta_hold;
        int          lat;

        //        y              e              d              delta
        vecs[0] = {32'h0080_0000, 32'h0100_0000, 32'h0040_0000, 32'h0040_0000};
        vecs[1] = {32'hFF80_0000, 32'h0100_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[2] = {32'h0180_0000, 32'h0100_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[3] = {32'h0100_0000, 32'h0100_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[4] = {32'h0080_0000, 32'hFE00_0000, 32'h0040_0000, 32'hFF80_0000};
        vecs[5] = {32'h0080_0000, 32'hFFFF_FFFF, 32'h0040_0000, 32'hFFFF_FFFF};
        vecs[6] = {32'h0080_0000, 32'h7FFF_FFFF, 32'h0040_0000, 32'h1FFF_FFFF};
        vecs[7] = {32'h0040_0000, 32'h0100_0000, 32'h0030_0000, 32'h0030_0000};
        vecs[8] = {32'h00C0_0000, 32'h0200_0000, 32'h0030_0000, 32'h0060_0000};
        vecs[9] = {32'h0000_0001, 32'h0100_0000, 32'h0000_0000, 32'h0000_0000};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        y_in      = 32'h0;
        err_in    = 32'h0;
        step();
        step();
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_delta", delta_out, 32'h0);
        check("rst_d", d_out, 32'h0);
        reset = 1'b0;
        step();

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            run_txn($sformatf("v%0d", i), vecs[i].y, vecs[i].e, d_got, delta_got);
            check($sformatf("v%0d_d", i), d_got, vecs[i].exp_d);
            check($sformatf("v%0d_delta", i), delta_got, vecs[i].exp_delta);
        end

        // Backpressure: a 10-cycle stall in HOLD while a second request waits.
        out_ready = 1'b0;
        y_in      = 32'h0080_0000;
        err_in    = ONE;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("bp_latency", lat, 32'd3);
        d_hold     = d_out;
        delta_hold = delta_out;
        check("bp_d", d_hold, 32'h0040_0000);
        check("bp_delta", delta_hold, 32'h0040_0000);
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                in_valid = 1'b1;
                y_in     = 32'h0040_0000;
                err_in   = ONE;
            end
            step();
            check($sformatf("bp_stall%0d_valid", k), {31'b0, out_valid}, 32'd1);
            check($sformatf("bp_stall%0d_in_ready", k), {31'b0, in_ready}, 32'd0);
            check($sformatf("bp_stall%0d_d", k), d_out, d_hold);
            check($sformatf("bp_stall%0d_delta", k), delta_out, delta_hold);
        end
        out_ready = 1'b1;
        step();
        check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        check("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
        step();
        in_valid = 1'b0;
        check("bp_second_busy", {31'b0, in_ready}, 32'd0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("bp_second_latency", lat, 32'd3);
        check("bp_second_d", d_out, 32'h0030_0000);
        check("bp_second_delta", delta_out, 32'h0030_0000);
        step();

        // Reset during MUL2: the result is dropped and the block restarts cleanly.
        out_ready = 1'b1;
        y_in      = 32'h0040_0000;
        err_in    = 32'h0200_0000;
        in_valid  = 1'b1;
        step();                       // MUL1
        in_valid = 1'b0;
        step();                       // MUL2
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mul2_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_mul2_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_mul2_delta", delta_out, 32'h0);
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("rst_mul2_quiet%0d", k), {31'b0, out_valid}, 32'd0);
        end
        run_txn("post_rst", 32'h0080_0000, 32'hFE00_0000, d_got, delta_got);
        check("post_rst_d", d_got, 32'h0040_0000);
        check("post_rst_delta", delta_got, 32'hFF80_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog: guarantees the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
